// File: rtl/uart_link.sv
// uart_link: full-duplex 8N1 serial link, one byte in flight per direction.
// Optional stop-bit framing check: define UART_FRAME_CHECK_EN.
module uart_link #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       rx,
    output logic       tx,
    output logic       rx_ready,
    output logic [7:0] rx_data,
    input  logic       tx_write,
    input  logic [7:0] tx_data,
    output logic       tx_finished,
    output logic       dbg_rx_sample
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_WAIT
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_STOP
    } tx_state_t;

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic          rx_fall;
    logic [1:0]    rx_vld;

    rx_state_t     rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_idx, rx_idx_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          rx_smp;
    logic          rx_load;

    tx_state_t     tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_idx, tx_idx_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic          tx_bit;
    logic          tx_done;
    logic          tx_done_q;

    // Two-flop synchroniser plus registered falling-edge detect; rx_prev
    // only tracks the line once real pin samples have reached rx_sync.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_vld  <= 2'b00;
            rx_prev <= 1'b0;
            rx_fall <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_vld  <= {rx_vld[0], 1'b1};
            rx_prev <= rx_sync & rx_vld[1];
            rx_fall <= rx_prev & ~rx_sync;
        end
    end

    // Receive sequencing: half-bit to the start centre, then whole bits.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_smp     = 1'b0;
        rx_load    = 1'b0;
        unique case (rx_state)
            R_IDLE: begin
                if (rx_fall) begin
                    rx_state_n = R_START;
                    rx_cnt_n   = '0;
                end
            end
            R_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_smp     = 1'b1;
                    rx_cnt_n   = '0;
                    rx_idx_n   = 3'd0;
                    rx_state_n = rx_sync ? R_IDLE : R_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            R_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_smp     = 1'b1;
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync, rx_shift[7:1]};
                    if (rx_idx == 3'd7) begin
                        rx_state_n = R_STOP;
                    end else begin
                        rx_idx_n = rx_idx + 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            R_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_smp   = 1'b1;
                    rx_cnt_n = '0;
`ifdef UART_FRAME_CHECK_EN
                    if (rx_sync) begin
                        rx_load    = 1'b1;
                        rx_state_n = R_IDLE;
                    end else begin
                        rx_state_n = R_WAIT;
                    end
`else
                    rx_load    = 1'b1;
                    rx_state_n = R_IDLE;
`endif
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            R_WAIT: begin
                if (rx_sync) begin
                    rx_state_n = R_IDLE;
                end
            end
            default: begin
                rx_state_n = R_IDLE;
            end
        endcase
    end

    // Receive state and registered strobes.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            rx_state      <= R_IDLE;
            rx_cnt        <= '0;
            rx_idx        <= 3'd0;
            rx_shift      <= 8'h00;
            rx_ready      <= 1'b0;
            rx_data       <= 8'h00;
            dbg_rx_sample <= 1'b0;
        end else begin
            rx_state      <= rx_state_n;
            rx_cnt        <= rx_cnt_n;
            rx_idx        <= rx_idx_n;
            rx_shift      <= rx_shift_n;
            rx_ready      <= rx_load;
            dbg_rx_sample <= rx_smp;
            if (rx_load) begin
                rx_data <= rx_shift;
            end
        end
    end

    // Transmit sequencing: each frame bit lasts exactly one bit period.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        tx_bit     = 1'b1;
        tx_done    = 1'b0;
        unique case (tx_state)
            T_IDLE: begin
                if (tx_write) begin
                    tx_state_n = T_START;
                    tx_cnt_n   = '0;
                    tx_shift_n = tx_data;
                end
            end
            T_START: begin
                tx_bit = 1'b0;
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = T_DATA;
                    tx_cnt_n   = '0;
                    tx_idx_n   = 3'd0;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            T_DATA: begin
                tx_bit = tx_shift[0];
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    if (tx_idx == 3'd7) begin
                        tx_state_n = T_STOP;
                    end else begin
                        tx_idx_n = tx_idx + 1'b1;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            T_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = T_IDLE;
                    tx_cnt_n   = '0;
                    tx_done    = 1'b1;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            default: begin
                tx_state_n = T_IDLE;
            end
        endcase
    end

    // Transmit state; pin and finish strobe are registered one cycle
    // behind the state so the strobe follows the end of the stop bit.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            tx_state    <= T_IDLE;
            tx_cnt      <= '0;
            tx_idx      <= 3'd0;
            tx_shift    <= 8'h00;
            tx          <= 1'b1;
            tx_done_q   <= 1'b0;
            tx_finished <= 1'b0;
        end else begin
            tx_state    <= tx_state_n;
            tx_cnt      <= tx_cnt_n;
            tx_idx      <= tx_idx_n;
            tx_shift    <= tx_shift_n;
            tx          <= tx_bit;
            tx_done_q   <= tx_done;
            tx_finished <= tx_done_q;
        end
    end

endmodule

// File: tb/tb_uart_link.sv
// tb_uart_link: randomized and directed checks of uart_link against a
// frame-level reference model (CLKS_PER_BIT = 8).
module tb_uart_link;

    localparam int CPB = 8;
    localparam int LAT = CPB / 2 + 9 * CPB + 4;
`ifdef UART_FRAME_CHECK_EN
    localparam bit FRAME_CHK = 1'b1;
`else
    localparam bit FRAME_CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_reset;
    logic       rx;
    logic       tx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       tx_write;
    logic [7:0] tx_data;
    logic       tx_finished;
    logic       dbg_rx_sample;

    uart_link #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .rx           (rx),
        .tx           (tx),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .tx_write     (tx_write),
        .tx_data      (tx_data),
        .tx_finished  (tx_finished),
        .dbg_rx_sample(dbg_rx_sample)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         due;
    } rx_exp_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    logic       tx_act = 1'b0;
    int         acc = 0;
    int         free_at = 0;
    logic [7:0] tx_byte = 8'h00;
    int         fq[$];
    rx_exp_t    rxq[$];
    logic [7:0] rx_data_m = 8'h00;
    logic [7:0] rx_log[$];
    int         dbg_cnt = 0;
    logic       p_rdy = 1'b0;
    logic       p_fin = 1'b0;
    logic       p_dbg = 1'b0;
    logic [9:0] fr;
    int         bidx;
    logic       exp_tx;
    logic       exp_fin;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference model: cycle count, reset and transmit acceptance.
    always @(posedge clk) begin
        cyc++;
        if (!n_reset) begin
            tx_act    = 1'b0;
            free_at   = 0;
            rx_data_m = 8'h00;
            fq.delete();
            rxq.delete();
        end else if (tx_write && cyc >= free_at) begin
            tx_act  = 1'b1;
            acc     = cyc;
            tx_byte = tx_data;
            free_at = cyc + 10 * CPB + 1;
            fq.push_back(cyc + 10 * CPB + 1);
        end
    end

    // Compare DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (cyc > 0) begin
            exp_tx = 1'b1;
            if (tx_act && cyc > acc && cyc <= acc + 10 * CPB) begin
                fr     = {1'b1, tx_byte, 1'b0};
                bidx   = (cyc - acc - 1) / CPB;
                exp_tx = fr[bidx];
            end
            chk("tx", tx, exp_tx);
            exp_fin = (fq.size() > 0 && fq[0] == cyc);
            chk("tx_finished", tx_finished, exp_fin);
            if (fq.size() > 0 && fq[0] <= cyc) void'(fq.pop_front());
            if (rx_ready) begin
                chk("rx_ready_expected", rx_ready, rxq.size() > 0);
                rx_log.push_back(rx_data);
                if (rxq.size() > 0) begin
                    chk("rx_data_new", rx_data, rxq[0].d);
                    n_cmp++;
                    if (cyc < rxq[0].due - 1 || cyc > rxq[0].due + 1) begin
                        n_bad++;
                        $display("FAIL rx_latency: got cycle %0d want %0d+-1",
                                 cyc, rxq[0].due);
                    end
                    rx_data_m = rxq[0].d;
                    void'(rxq.pop_front());
                end
            end else if (rxq.size() > 0 && cyc > rxq[0].due + 1) begin
                chk("rx_ready_missing", rx_ready, 1);
                void'(rxq.pop_front());
            end
            chk("rx_data", rx_data, rx_data_m);
            if (rx_ready) chk("rx_ready_run", p_rdy, 0);
            if (tx_finished) chk("tx_finished_run", p_fin, 0);
            if (dbg_rx_sample) begin
                chk("dbg_sample_run", p_dbg, 0);
                dbg_cnt++;
            end
            p_rdy = rx_ready;
            p_fin = tx_finished;
            p_dbg = dbg_rx_sample;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop,
                           input int nbits);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        if (nbits == 10 && (stop || !FRAME_CHK))
            rxq.push_back('{d, cyc + LAT});
        for (int i = 0; i < nbits; i++) begin
            rx = f[i];
            repeat (CPB) step();
        end
        rx = 1'b1;
    endtask

    task automatic send_tx(input logic [7:0] d);
        tx_data  = d;
        tx_write = 1'b1;
        step();
        tx_write = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         a;
        int         f_at;
        int         d0;
        int         n0;
        logic [9:0] got;

        n_reset  = 1'b0;
        rx       = 1'b0;
        tx_write = 1'b0;
        tx_data  = 8'h00;
        repeat (3) step();
        chk("reset_tx", tx, 1);
        chk("reset_rx_ready", rx_ready, 0);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_tx_finished", tx_finished, 0);
        chk("reset_dbg", dbg_rx_sample, 0);
        n_reset = 1'b1;
        repeat (30) step();
        chk("no_start_while_low", dbg_cnt, 0);
        rx = 1'b1;
        repeat (10) step();

        // transmit 8'hA5, ignored 8'hFF at +20, write in finish cycle
        got  = '0;
        f_at = -1;
        tx_data  = 8'hA5;
        tx_write = 1'b1;
        a = cyc + 1;
        for (int i = 0; i < 120 && f_at < 0; i++) begin
            step();
            tx_write = (cyc == a + 20);
            tx_data  = (cyc == a + 20) ? 8'hFF : 8'hA5;
            if (cyc > a && (cyc - a - 1) % CPB == CPB / 2 &&
                (cyc - a - 1) / CPB < 10)
                got[(cyc - a - 1) / CPB] = tx;
            if (tx_finished) f_at = cyc;
        end
        chk("tx_pattern_a5", got, 10'b1101001010);
        chk("tx_finish_offset", f_at - a, 81);
        send_tx(8'h5A);
        step();
        chk("tx_accept_in_finish_cycle", tx, 0);
        repeat (90) step();

        // back-to-back receive
        d0 = dbg_cnt;
        n0 = rx_log.size();
        send_rx(8'h3C, 1'b1, 10);
        send_rx(8'hC3, 1'b1, 10);
        repeat (20) step();
        chk("rx_pair_count", rx_log.size() - n0, 2);
        if (rx_log.size() >= n0 + 2) begin
            chk("rx_first", rx_log[n0], 8'h3C);
            chk("rx_second", rx_log[n0 + 1], 8'hC3);
        end
        chk("dbg_per_two_frames", dbg_cnt - d0, 20);

        // false start then a good frame
        d0 = dbg_cnt;
        n0 = rx_log.size();
        rx = 1'b0;
        step();
        step();
        rx = 1'b1;
        repeat (20) step();
        chk("false_start_dbg", dbg_cnt - d0, 1);
        chk("false_start_no_ready", rx_log.size() - n0, 0);
        send_rx(8'h55, 1'b1, 10);
        repeat (20) step();
        chk("after_false_start", rx_data, 8'h55);

        // framing error
        d0 = dbg_cnt;
        n0 = rx_log.size();
        send_rx(8'h81, 1'b0, 10);
        repeat (20) step();
        chk("framing_dbg", dbg_cnt - d0, 10);
`ifdef UART_FRAME_CHECK_EN
        chk("framing_dropped", rx_log.size() - n0, 0);
        chk("framing_retained", rx_data, 8'h55);
`else
        chk("framing_delivered", rx_data, 8'h81);
`endif

        // reset in the middle of both frames
        fork
            send_tx(8'h9C);
            send_rx(8'h6E, 1'b1, 5);
        join
        n_reset = 1'b0;
        step();
        chk("reset_mid_tx", tx, 1);
        step();
        n_reset = 1'b1;
        repeat (20) step();
        n0 = rx_log.size();
        fork
            send_tx(8'h12);
            send_rx(8'h12, 1'b1, 10);
        join
        repeat (100) step();
        chk("fresh_rx_count", rx_log.size() - n0, 1);
        chk("fresh_rx_data", rx_data, 8'h12);

        // randomized concurrent traffic
        fork
            begin
                repeat (12) begin
                    repeat ($urandom_range(0, 15)) step();
                    send_rx(8'($urandom), 1'b1, 10);
                end
            end
            begin
                for (int i = 0; i < 1400; i++) begin
                    step();
                    tx_write = ($urandom_range(0, 29) == 0);
                    tx_data  = 8'($urandom);
                end
                tx_write = 1'b0;
            end
        join
        repeat (200) step();
        chk("rx_pending", rxq.size(), 0);
        chk("tx_finish_pending", fq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
